ethernet_phy_init: RTL and testbench
====================================

Name: ethernet_phy_init

Overview:
Parametrised PHY bring-up sequencer, the next generation of the Ethernet top-level init FSM. It holds the PHY in hardware reset, then waits a settle time. It then issues a table of N SMI register writes and polls a PHY status register until a mask bit sets, retrying the whole sequence on timeout. It drives the SMI master through a start/ready handshake and gates the RX path with its ready output.

Parameters:
RESET_CYCLES, 2501, clk cycles phy_reset_n is held low (>=1).
SETTLE_CYCLES, 2501, clk cycles after reset release before the first SMI access (>=1).
N_WRITES, 2, number of SMI writes in WR_TABLE (0..8).
WR_TABLE, {5'd0,16'h1200,5'd4,16'h01E1}, N_WRITES packed 21-bit {reg[4:0],data[15:0]} entries; entry 0 in bits [20:0], issued first.
POLL_EN, 1, 1 = poll POLL_REG after the writes; 0 = go READY after the last write.
POLL_REG, 5'd1, PHY register read during polling.
POLL_MASK, 16'h0004, done when (smi_rd_data & POLL_MASK) == POLL_MASK.
POLL_GAP, 1024, idle clk cycles between consecutive polls (>=1).
POLL_LIMIT, 64, maximum polls per attempt before timeout (>=1).
MAX_RETRY, 3, full-sequence retries after the first attempt before FAIL (0..15).

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous active-high reset.
restart  in  1  one-cycle pulse; restarts the sequence from RST_HOLD when in READY or FAIL, ignored otherwise.
phy_reset_n  out  1  PHY hardware reset, active low.
smi_start  out  1  one-cycle request to the SMI master.
smi_write  out  1  1 = write, 0 = read; valid with smi_start.
smi_register  out  5  PHY register address; held from smi_start until the transaction completes.
smi_content  out  16  write data; held from smi_start until the transaction completes.
smi_ready  in  1  SMI master idle; drops on the edge that samples smi_start, rises when the transaction completes.
smi_rd_data  in  16  read data; valid while smi_ready=1 after a read.
ready  out  1  sequence complete, link up.
link_up  out  1  last poll matched POLL_MASK (forced 1 when POLL_EN=0 on reaching READY).
error  out  1  retries exhausted.
retry_cnt  out  4  retries consumed in the current run.

Behaviour:
- Reset is asynchronous and active-high; clk is the clock.
- Reset values: state RST_HOLD, phy_reset_n=0, smi_start=0, smi_write=0, smi_register=0, smi_content=0, ready=0, link_up=0, error=0, retry_cnt=0. All outputs are registered.
- RST_HOLD: phy_reset_n=0, count up to RESET_CYCLES, then go to SETTLE with phy_reset_n=1.
- SETTLE: count up to SETTLE_CYCLES, then go to WR_ISSUE with idx=0. If N_WRITES=0, go to POLL_ISSUE, or to READY when POLL_EN=0.
- WR_ISSUE: when smi_ready=1, pulse smi_start for 1 cycle with smi_write=1, smi_register=WR_TABLE[idx] reg, smi_content=WR_TABLE[idx] data, then go to WR_WAIT.
- WR_WAIT: ignore smi_ready in the first cycle. After that, smi_ready=1 means idx+1; if idx+1==N_WRITES, go to POLL_ISSUE (or READY), else back to WR_ISSUE.
- POLL_ISSUE: when smi_ready=1, pulse smi_start with smi_write=0, smi_register=POLL_REG, smi_content=0; increment poll_cnt.
- POLL_WAIT: ignore the first cycle, then on smi_ready=1 sample smi_rd_data.
  - Match: link_up=1, go to READY.
  - No match and poll_cnt<POLL_LIMIT: go to POLL_GAP.
  - Otherwise timeout.
- POLL_GAP: wait POLL_GAP cycles, then return to POLL_ISSUE.
- Timeout: if retry_cnt<MAX_RETRY, increment retry_cnt, clear poll_cnt, go to RST_HOLD (phy_reset_n drops next cycle). Else go to FAIL.
- READY: ready=1; all SMI outputs idle (smi_start=0).
- FAIL: error=1, ready=0, phy_reset_n stays 1.
- restart in READY/FAIL: next cycle RST_HOLD; ready, error, link_up and retry_cnt clear; counters clear.
- smi_start is never asserted outside WR_ISSUE/POLL_ISSUE and never on consecutive cycles.
- Counter widths: $clog2(max+1) of each bound; no wrap inside a phase.
- Asynchronous reset mid-transaction returns everything to reset values; the SMI master is reset by the same signal.
- Latency at default parameters with zero-latency SMI: READY no earlier than RESET_CYCLES + SETTLE_CYCLES + per-transaction SMI time.

Test Plan:
1. RESET_CYCLES=4, SETTLE_CYCLES=3, instant-ish SMI model (ready low 5 cycles), poll returns 16'h0004 first time -> phy_reset_n low exactly 4 cycles; writes reg4=16'h01E1 then reg0=16'h1200; one read of reg1; ready=1, link_up=1, error=0.
2. Poll returns 16'h0000 twice then 16'h0004, POLL_GAP=8 -> 3 smi_start reads spaced >=8 idle cycles; ready asserts after the third; retry_cnt=0.
3. Poll always 16'h0000, POLL_LIMIT=2, MAX_RETRY=1 -> 2 polls; phy_reset_n re-pulses low for 4 cycles; retry_cnt=1; 2 more polls; error=1, ready=0.
4. From FAIL, pulse restart while the SMI model returns 16'h0004 -> retry_cnt=0 and error=0 next cycle; full sequence reruns; ready=1.
5. N_WRITES=0, POLL_EN=0 -> no smi_start ever; ready=1 and link_up=1 exactly RESET_CYCLES+SETTLE_CYCLES (+1 registration) cycles after reset release.
6. Assert reset during the second WR_WAIT -> all outputs return to reset values immediately; after release the sequence restarts from entry 0.

Source files
------------

// File: rtl/ethernet_phy_init.sv
`default_nettype none
// ============================================================================
// Module   : ethernet_phy_init
// Purpose  : PHY bring-up sequencer. Holds the PHY in hardware reset, waits a
//            settle time, issues a table of SMI register writes, then polls a
//            status register until a mask matches. A timed-out poll phase
//            retries the whole sequence up to MAX_RETRY times before FAIL.
// Ports    : clk, reset (async, active-high), restart (pulse, READY/FAIL only)
//            phy_reset_n             - PHY hardware reset, active low
//            smi_start/write/register/content - SMI request, held per txn
//            smi_ready, smi_rd_data  - SMI master status / read data
//            ready, link_up, error, retry_cnt - sequencer status
// Revision : 1.0 - initial release
// ============================================================================
module ethernet_phy_init #(
  parameter int unsigned RESET_CYCLES  = 2501,
  parameter int unsigned SETTLE_CYCLES = 2501,
  parameter int unsigned N_WRITES      = 2,
  parameter logic [((N_WRITES > 0) ? N_WRITES : 1)*21-1:0] WR_TABLE =
    {5'd0, 16'h1200, 5'd4, 16'h01E1},
  parameter bit          POLL_EN       = 1'b1,
  parameter logic [4:0]  POLL_REG      = 5'd1,
  parameter logic [15:0] POLL_MASK     = 16'h0004,
  parameter int unsigned POLL_GAP      = 1024,
  parameter int unsigned POLL_LIMIT    = 64,
  parameter int unsigned MAX_RETRY     = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        restart,
  output logic        phy_reset_n,
  output logic        smi_start,
  output logic        smi_write,
  output logic [4:0]  smi_register,
  output logic [15:0] smi_content,
  input  logic        smi_ready,
  input  logic [15:0] smi_rd_data,
  output logic        ready,
  output logic        link_up,
  output logic        error,
  output logic [3:0]  retry_cnt
);

  // One phase counter is shared by RST_HOLD, SETTLE and POLL_GAP, so it is
  // sized for the largest of the three bounds.
  localparam int unsigned CNT_MAX_RS = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CNT_MAX    = (CNT_MAX_RS > POLL_GAP) ? CNT_MAX_RS : POLL_GAP;
  localparam int unsigned CNT_W      = $clog2(CNT_MAX + 1);
  localparam int unsigned PC_W       = $clog2(POLL_LIMIT + 1);
  localparam int unsigned IDX_W      = (N_WRITES > 1) ? $clog2(N_WRITES) : 1;
  localparam int unsigned TBL_DEPTH  = 1 << IDX_W;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(POLL_GAP - 1);
  localparam logic [PC_W-1:0]  PC_LIMIT    = PC_W'(POLL_LIMIT);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'((N_WRITES > 0) ? (N_WRITES - 1) : 0);
  localparam logic [3:0]       RETRY_MAX   = 4'(MAX_RETRY);

  typedef enum logic [3:0] {
    S_RST_HOLD   = 4'd0,
    S_SETTLE     = 4'd1,
    S_WR_ISSUE   = 4'd2,
    S_WR_WAIT    = 4'd3,
    S_POLL_ISSUE = 4'd4,
    S_POLL_WAIT  = 4'd5,
    S_POLL_GAP   = 4'd6,
    S_READY      = 4'd7,
    S_FAIL       = 4'd8
  } state_t;

  // Write table unpacked to a power-of-two depth so the index select is
  // always in range; unused slots read as zero.
  logic [20:0] w_table [TBL_DEPTH];

  for (genvar gi = 0; gi < int'(TBL_DEPTH); gi++) begin : g_tbl
    if (gi < int'(N_WRITES)) begin : g_used
      assign w_table[gi] = WR_TABLE[gi*21 +: 21];
    end else begin : g_pad
      assign w_table[gi] = 21'd0;
    end
  end

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [PC_W-1:0]   poll_cnt_q, poll_cnt_d;
  logic              first_q, first_d;     // first WAIT cycle: smi_ready still stale
  logic              phy_reset_n_q, phy_reset_n_d;
  logic              smi_start_q, smi_start_d;
  logic              smi_write_q, smi_write_d;
  logic [4:0]        smi_register_q, smi_register_d;
  logic [15:0]       smi_content_q, smi_content_d;
  logic              ready_q, ready_d;
  logic              link_up_q, link_up_d;
  logic              error_q, error_d;
  logic [3:0]        retry_cnt_q, retry_cnt_d;
  logic [20:0]       w_entry;

  assign w_entry = w_table[idx_q];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_RST_HOLD;
      cnt_q          <= '0;
      idx_q          <= '0;
      poll_cnt_q     <= '0;
      first_q        <= 1'b0;
      phy_reset_n_q  <= 1'b0;
      smi_start_q    <= 1'b0;
      smi_write_q    <= 1'b0;
      smi_register_q <= 5'd0;
      smi_content_q  <= 16'd0;
      ready_q        <= 1'b0;
      link_up_q      <= 1'b0;
      error_q        <= 1'b0;
      retry_cnt_q    <= 4'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      poll_cnt_q     <= poll_cnt_d;
      first_q        <= first_d;
      phy_reset_n_q  <= phy_reset_n_d;
      smi_start_q    <= smi_start_d;
      smi_write_q    <= smi_write_d;
      smi_register_q <= smi_register_d;
      smi_content_q  <= smi_content_d;
      ready_q        <= ready_d;
      link_up_q      <= link_up_d;
      error_q        <= error_d;
      retry_cnt_q    <= retry_cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    idx_d          = idx_q;
    poll_cnt_d     = poll_cnt_q;
    first_d        = 1'b0;
    phy_reset_n_d  = phy_reset_n_q;
    smi_start_d    = 1'b0;
    smi_write_d    = smi_write_q;
    smi_register_d = smi_register_q;
    smi_content_d  = smi_content_q;
    ready_d        = ready_q;
    link_up_d      = link_up_q;
    error_d        = error_q;
    retry_cnt_d    = retry_cnt_q;

    unique case (state_q)
      S_RST_HOLD: begin
        phy_reset_n_d = 1'b0;
        if (cnt_q == RST_LAST) begin
          cnt_d         = '0;
          phy_reset_n_d = 1'b1;
          state_d       = S_SETTLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d = '0;
          idx_d = '0;
          if (N_WRITES > 0) begin
            state_d = S_WR_ISSUE;
          end else if (POLL_EN) begin
            state_d = S_POLL_ISSUE;
          end else begin
            state_d   = S_READY;
            ready_d   = 1'b1;
            link_up_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_WR_ISSUE: begin
        if (smi_ready) begin
          smi_start_d    = 1'b1;
          smi_write_d    = 1'b1;
          smi_register_d = w_entry[20:16];
          smi_content_d  = w_entry[15:0];
          first_d        = 1'b1;
          state_d        = S_WR_WAIT;
        end
      end

      S_WR_WAIT: begin
        if (!first_q && smi_ready) begin
          if (idx_q == IDX_LAST) begin
            if (POLL_EN) begin
              state_d = S_POLL_ISSUE;
            end else begin
              state_d   = S_READY;
              ready_d   = 1'b1;
              link_up_d = 1'b1;
            end
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_WR_ISSUE;
          end
        end
      end

      S_POLL_ISSUE: begin
        if (smi_ready) begin
          smi_start_d    = 1'b1;
          smi_write_d    = 1'b0;
          smi_register_d = POLL_REG;
          smi_content_d  = 16'd0;
          poll_cnt_d     = poll_cnt_q + 1'b1;
          first_d        = 1'b1;
          state_d        = S_POLL_WAIT;
        end
      end

      S_POLL_WAIT: begin
        if (!first_q && smi_ready) begin
          if ((smi_rd_data & POLL_MASK) == POLL_MASK) begin
            link_up_d = 1'b1;
            ready_d   = 1'b1;
            state_d   = S_READY;
          end else if (poll_cnt_q < PC_LIMIT) begin
            cnt_d   = '0;
            state_d = S_POLL_GAP;
          end else if (retry_cnt_q < RETRY_MAX) begin
            // Timeout with retries left: rerun the full sequence from reset.
            retry_cnt_d   = retry_cnt_q + 1'b1;
            poll_cnt_d    = '0;
            cnt_d         = '0;
            idx_d         = '0;
            phy_reset_n_d = 1'b0;
            state_d       = S_RST_HOLD;
          end else begin
            error_d = 1'b1;
            ready_d = 1'b0;
            state_d = S_FAIL;
          end
        end
      end

      S_POLL_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = S_POLL_ISSUE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_READY, S_FAIL: begin
        if (restart) begin
          state_d       = S_RST_HOLD;
          phy_reset_n_d = 1'b0;
          ready_d       = 1'b0;
          error_d       = 1'b0;
          link_up_d     = 1'b0;
          retry_cnt_d   = 4'd0;
          cnt_d         = '0;
          idx_d         = '0;
          poll_cnt_d    = '0;
        end
      end

      default: begin
        state_d = S_RST_HOLD;
      end
    endcase
  end

  assign phy_reset_n  = phy_reset_n_q;
  assign smi_start    = smi_start_q;
  assign smi_write    = smi_write_q;
  assign smi_register = smi_register_q;
  assign smi_content  = smi_content_q;
  assign ready        = ready_q;
  assign link_up      = link_up_q;
  assign error        = error_q;
  assign retry_cnt    = retry_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ethernet_phy_init.sv
`default_nettype none
// ============================================================================
// Module   : tb_ethernet_phy_init
// Purpose  : Scoreboard bench for ethernet_phy_init. A behavioural SMI slave
//            with random latency answers reads from a response queue; a
//            run-level model derives the expected SMI transactions and final
//            status from the chosen poll responses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ethernet_phy_init;

  localparam int R     = 4;
  localparam int S     = 3;
  localparam int GAP   = 8;
  localparam int LIMIT = 3;
  localparam int MAXR  = 1;
  localparam logic [4:0]  PREG = 5'd1;
  localparam logic [15:0] MASK = 16'h0004;

  logic        clk     = 1'b0;
  logic        reset   = 1'b1;
  logic        restart = 1'b0;
  logic        phy_reset_n, smi_start, smi_write, ready, link_up, error;
  logic [4:0]  smi_register;
  logic [15:0] smi_content;
  logic [3:0]  retry_cnt;
  logic        s_ready;
  logic [15:0] s_data;

  // Second instance: no writes, no polling.
  logic        z_restart = 1'b0;
  logic        z_smi_ready = 1'b1;
  logic [15:0] z_rd_data = 16'h0;
  logic        z_phy_reset_n, z_smi_start, z_smi_write, z_ready, z_link_up, z_error;
  logic [4:0]  z_smi_register;
  logic [15:0] z_smi_content;
  logic [3:0]  z_retry_cnt;

  always #5 clk = ~clk;

  ethernet_phy_init #(
    .RESET_CYCLES(R), .SETTLE_CYCLES(S), .N_WRITES(2),
    .WR_TABLE({5'd0, 16'h1200, 5'd4, 16'h01E1}),
    .POLL_EN(1'b1), .POLL_REG(PREG), .POLL_MASK(MASK),
    .POLL_GAP(GAP), .POLL_LIMIT(LIMIT), .MAX_RETRY(MAXR)
  ) dut (
    .clk(clk), .reset(reset), .restart(restart), .phy_reset_n(phy_reset_n),
    .smi_start(smi_start), .smi_write(smi_write), .smi_register(smi_register),
    .smi_content(smi_content), .smi_ready(s_ready), .smi_rd_data(s_data),
    .ready(ready), .link_up(link_up), .error(error), .retry_cnt(retry_cnt)
  );

  ethernet_phy_init #(
    .RESET_CYCLES(R), .SETTLE_CYCLES(S), .N_WRITES(0), .WR_TABLE(21'd0),
    .POLL_EN(1'b0)
  ) dut0 (
    .clk(clk), .reset(reset), .restart(z_restart), .phy_reset_n(z_phy_reset_n),
    .smi_start(z_smi_start), .smi_write(z_smi_write), .smi_register(z_smi_register),
    .smi_content(z_smi_content), .smi_ready(z_smi_ready), .smi_rd_data(z_rd_data),
    .ready(z_ready), .link_up(z_link_up), .error(z_error), .retry_cnt(z_retry_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [4:0]  t_reg [2] = '{5'd4, 5'd0};
  logic [15:0] t_dat [2] = '{16'h01E1, 16'h1200};

  logic [21:0] exp_q [$];   // {write, reg, content}
  logic [15:0] resp_q [$];  // read data the slave returns, in order
  logic [6:0]  out_q [$];   // {ready, link_up, error, retry_cnt}

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Run-level model: each attempt issues the table then up to LIMIT polls;
  // poll number match_at (1-based over the run) matches, 0 = never.
  task automatic plan(input int match_at);
    int k = 0;
    logic [15:0] d;
    for (int a = 0; a <= MAXR; a++) begin
      for (int e = 0; e < 2; e++) exp_q.push_back({1'b1, t_reg[e], t_dat[e]});
      for (int p = 0; p < LIMIT; p++) begin
        k++;
        exp_q.push_back({1'b0, PREG, 16'h0000});
        if (k == match_at) begin
          d = 16'($urandom) | MASK;
          resp_q.push_back(d);
          out_q.push_back({1'b1, 1'b1, 1'b0, 4'(a)});
          return;
        end
        d = 16'($urandom) & ~MASK;
        resp_q.push_back(d);
      end
    end
    out_q.push_back({1'b0, 1'b0, 1'b1, 4'(MAXR)});
  endtask

  // Behavioural SMI master: ready drops on the edge sampling start, returns
  // after 1..6 cycles with read data.
  int          s_cnt;
  logic        s_busy;
  logic [15:0] s_pend;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      s_ready <= 1'b1; s_busy <= 1'b0; s_cnt <= 0; s_data <= 16'h0; s_pend <= 16'h0;
    end else if (s_busy) begin
      if (s_cnt <= 1) begin
        s_ready <= 1'b1; s_busy <= 1'b0; s_data <= s_pend;
      end else begin
        s_cnt <= s_cnt - 1;
      end
    end else if (s_ready && smi_start) begin
      s_ready <= 1'b0; s_busy <= 1'b1; s_cnt <= int'($urandom_range(1, 6));
      if (!smi_write) begin
        if (resp_q.size() > 0) s_pend <= resp_q.pop_front();
        else s_pend <= 16'h0;
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: SMI transactions, start spacing, and final status.
  logic prev_start = 1'b0;
  logic prev_done  = 1'b0;
  int   last_rd    = -1;
  int   n_wr_seen  = 0;
  always @(negedge clk) begin
    if (reset) begin
      prev_start = 1'b0; prev_done = 1'b0; last_rd = -1;
    end else begin
      if (smi_start) begin
        chk("start_not_back_to_back", {31'd0, prev_start}, 0);
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_smi_start: got %0h expected none",
                   {smi_write, smi_register, smi_content});
        end else begin
          chk("smi_txn", {smi_write, smi_register, smi_content}, exp_q.pop_front());
        end
        if (smi_write) n_wr_seen++;
        else begin
          if (last_rd >= 0) chk("poll_spacing_ge_gap", {31'd0, (cyc - last_rd) >= GAP}, 1);
          last_rd = cyc;
        end
      end
      prev_start = smi_start;
      if ((ready || error) && !prev_done) begin
        if (out_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_outcome: got %0h expected none",
                   {ready, link_up, error, retry_cnt});
        end else begin
          chk("outcome", {ready, link_up, error, retry_cnt}, out_q.pop_front());
        end
      end
      prev_done = ready || error;
    end
  end

  // phy_reset_n low pulse width.
  int low_n = 0;
  always @(negedge clk) begin
    if (reset) low_n = 0;
    else if (!phy_reset_n) low_n++;
    else if (low_n != 0) begin
      chk("phy_reset_low_cycles", low_n, R);
      low_n = 0;
    end
  end

  int n_start0 = 0;
  always @(negedge clk) if (!reset && z_smi_start) n_start0++;

  // No-write/no-poll instance: READY latency after first reset release.
  initial begin
    int lat = 0;
    @(negedge reset);
    while (!z_ready && lat < 100) begin
      @(posedge clk); lat++; #1;
    end
    n_cmp++;
    if (!(lat == R + S || lat == R + S + 1)) begin
      n_bad++;
      $display("FAIL nopoll_ready_latency: got %0d expected %0d (or +1)", lat, R + S);
    end
    chk("nopoll_link_up", {31'd0, z_link_up}, 1);
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_phy_reset_n"}, {31'd0, phy_reset_n}, 0);
    chk({tag, "_smi_start"}, {31'd0, smi_start}, 0);
    chk({tag, "_smi_write"}, {31'd0, smi_write}, 0);
    chk({tag, "_smi_register"}, {27'd0, smi_register}, 0);
    chk({tag, "_smi_content"}, {16'd0, smi_content}, 0);
    chk({tag, "_ready"}, {31'd0, ready}, 0);
    chk({tag, "_link_up"}, {31'd0, link_up}, 0);
    chk({tag, "_error"}, {31'd0, error}, 0);
    chk({tag, "_retry_cnt"}, {28'd0, retry_cnt}, 0);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!(ready || error) && n < 3000) begin
      @(negedge clk); n++;
    end
    if (!(ready || error)) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: got no ready/error expected one within 3000 cycles", name);
    end else begin
      chk({name, "_all_txns_seen"}, exp_q.size(), 0);
    end
  endtask

  task automatic pulse_restart();
    @(negedge clk); restart = 1'b1;
    @(negedge clk); restart = 1'b0;
  endtask

  initial begin
    int n;
    int base;
    #1;
    chk_reset("reset");

    // First poll matches.
    plan(1);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    wait_done("first_poll_match");

    // Two misses then a match; a second restart during RST_HOLD is ignored.
    plan(3);
    pulse_restart();
    chk("restart_clears_ready", {31'd0, ready}, 0);
    pulse_restart();
    wait_done("third_poll_match");

    // Never matches: one retry, then FAIL.
    plan(0);
    pulse_restart();
    wait_done("timeout_to_fail");
    chk("fail_phy_reset_n_high", {31'd0, phy_reset_n}, 1);

    // Restart out of FAIL.
    plan(1);
    pulse_restart();
    chk("restart_clears_retry", {28'd0, retry_cnt}, 0);
    chk("restart_clears_error", {31'd0, error}, 0);
    wait_done("restart_from_fail");

    // Randomized match positions, including retry and FAIL paths.
    for (int i = 0; i < 5; i++) begin
      plan(int'($urandom_range(0, LIMIT * (MAXR + 1))));
      pulse_restart();
      wait_done("random_run");
    end

    // Reset in the second WR_WAIT.
    plan(1);
    base = n_wr_seen;
    pulse_restart();
    n = 0;
    while (n_wr_seen < base + 2 && n < 2000) begin
      @(negedge clk); n++;
    end
    chk("second_write_reached", {31'd0, n_wr_seen >= base + 2}, 1);
    #1 reset = 1'b1;
    #1 chk_reset("midrun_reset");
    exp_q.delete(); out_q.delete(); resp_q.delete();
    plan(1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    wait_done("after_midrun_reset");

    chk("nopoll_final_ready", {31'd0, z_ready}, 1);
    chk("nopoll_final_link_up", {31'd0, z_link_up}, 1);
    chk("nopoll_final_error", {31'd0, z_error}, 0);
    chk("nopoll_no_smi_start", n_start0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
